// File: rtl/run_length_packer.sv
// Packs a valid-qualified sample stream into (value, run length) tokens.
// Closed runs are buffered in a small token FIFO with a valid/ready output.
module run_length_packer #(
  parameter int DATA_W     = 3,
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  input  logic                          flush,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_value,
  output logic [LEN_W-1:0]              out_len,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LEN_W-1:0] MAX_LEN = '1;

  logic              have_run_q, have_run_d;
  logic [DATA_W-1:0] cur_val_q, cur_val_d;
  logic [LEN_W-1:0]  cur_len_q, cur_len_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] val_mem_q [FIFO_DEPTH];
  logic [LEN_W-1:0]  len_mem_q [FIFO_DEPTH];

  logic              fifo_full;
  logic              accept;
  logic              pop;
  logic              push;
  logic [DATA_W-1:0] push_val;
  logic [LEN_W-1:0]  push_len;

  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign in_ready   = ~rst & ~flush & ~fifo_full;
  assign accept     = in_valid & in_ready;
  assign out_valid  = (count_q != '0);
  assign pop        = out_valid & out_ready;
  assign out_value  = val_mem_q[rd_ptr_q];
  assign out_len    = len_mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  always_comb begin
    have_run_d = have_run_q;
    cur_val_d  = cur_val_q;
    cur_len_d  = cur_len_q;
    push       = 1'b0;
    push_val   = cur_val_q;
    push_len   = cur_len_q;
    if (accept) begin
      if (!have_run_q) begin
        have_run_d = 1'b1;
        cur_val_d  = in_data;
        cur_len_d  = LEN_W'(1);
      end else if (in_data == cur_val_q && cur_len_q != MAX_LEN) begin
        cur_len_d = cur_len_q + LEN_W'(1);
      end else begin
        push      = 1'b1;
        cur_val_d = in_data;
        cur_len_d = LEN_W'(1);
      end
    end else if (flush && have_run_q && !fifo_full) begin
      // A flush that meets a full FIFO simply retries next cycle.
      push       = 1'b1;
      have_run_d = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_run_q <= 1'b0;
      cur_val_q  <= '0;
      cur_len_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        val_mem_q[i] <= '0;
        len_mem_q[i] <= '0;
      end
    end else begin
      have_run_q <= have_run_d;
      cur_val_q  <= cur_val_d;
      cur_len_q  <= cur_len_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      if (push) begin
        val_mem_q[wr_ptr_q] <= push_val;
        len_mem_q[wr_ptr_q] <= push_len;
      end
    end
  end

endmodule

// File: tb/tb_run_length_packer.sv
// Directed bench for run_length_packer: expected tokens are queued when the
// closing stimulus is driven and compared as the DUT hands tokens out.
module tb_run_length_packer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_data;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic [2:0] out_value;
  logic [3:0] out_len;
  logic       out_ready;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;
  logic [6:0] exp_q [$];

  run_length_packer #(.DATA_W(3), .LEN_W(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_value  (out_value),
    .out_len    (out_len),
    .out_ready  (out_ready),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Token handed over on this edge: compare against the scoreboard head.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [6:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL unexpected_token observed=(%0d,%0d) expected=none", out_value, out_len);
      end else begin
        e = exp_q.pop_front();
        assert ({out_value, out_len} === e) else begin
          failures++;
          $error("FAIL token observed=(%0d,%0d) expected=(%0d,%0d)",
                 out_value, out_len, e[6:4], e[3:0]);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [2:0] d, input logic f);
    in_valid = v;
    in_data  = d;
    flush    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_tok(input logic [2:0] v, input logic [3:0] l);
    exp_q.push_back({v, l});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_count0"}, 32'(fifo_count), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_value", 32'(out_value), 32'd0);
    chk("rst_out_len",   32'(out_len),   32'd0);
    chk("rst_count",     32'(fifo_count), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // 1: three runs of three, closed by value changes and a flush
    repeat (3) drive(1, 3'd1, 0);
    chk("t1_no_early_token", 32'(out_valid), 32'd0);
    expect_tok(3'd1, 4'd3);
    drive(1, 3'd2, 0);
    chk("t1_lat_valid", 32'(out_valid), 32'd1);
    chk("t1_lat_len",   32'(out_len),   32'd3);
    repeat (2) drive(1, 3'd2, 0);
    expect_tok(3'd2, 4'd3);
    drive(1, 3'd3, 0);
    chk("t1_lat2_value", 32'(out_value), 32'd2);
    repeat (2) drive(1, 3'd3, 0);
    expect_tok(3'd3, 4'd3);
    drive(0, 3'd0, 1);
    chk("t1_flush_valid", 32'(out_valid), 32'd1);
    chk("t1_flush_value", 32'(out_value), 32'd3);
    drive(0, 3'd0, 0);
    drain("t1");

    // 2: counter wrap 7 -> 1
    repeat (3) drive(1, 3'd7, 0);
    expect_tok(3'd7, 4'd3);
    repeat (3) drive(1, 3'd1, 0);
    expect_tok(3'd1, 4'd3);
    drive(0, 3'd0, 1);
    drive(0, 3'd0, 0);
    drain("t2");

    // 3: run longer than MAX_LEN splits at 15
    for (int i = 0; i < 20; i++) begin
      if (i == 15) expect_tok(3'd5, 4'd15);
      drive(1, 3'd5, 0);
      if (i == 15) chk("t3_max_len", 32'(out_len), 32'd15);
    end
    expect_tok(3'd5, 4'd5);
    drive(0, 3'd0, 1);
    drive(0, 3'd0, 0);
    drain("t3");

    // 4: backpressure fills the FIFO, then drains in order
    out_ready = 1'b0;
    drive(1, 3'd1, 0);
    expect_tok(3'd1, 4'd1); drive(1, 3'd2, 0);
    expect_tok(3'd2, 4'd1); drive(1, 3'd1, 0);
    expect_tok(3'd1, 4'd1); drive(1, 3'd2, 0);
    expect_tok(3'd2, 4'd1); drive(1, 3'd1, 0);
    chk("t4_full_count",    32'(fifo_count), 32'd4);
    chk("t4_full_in_ready", 32'(in_ready),   32'd0);
    repeat (2) drive(1, 3'd2, 0);
    chk("t4_stall_count", 32'(fifo_count), 32'd4);
    out_ready = 1'b1;
    drive(1, 3'd2, 0);
    chk("t4_ready_back", 32'(in_ready),   32'd1);
    chk("t4_after_pop",  32'(fifo_count), 32'd3);
    expect_tok(3'd1, 4'd1);
    drive(1, 3'd2, 0);
    expect_tok(3'd2, 4'd1);
    drive(0, 3'd0, 1);
    drive(0, 3'd0, 0);
    drain("t4");

    // 5: idle gaps do not end a run; a long flush emits once
    drive(1, 3'd4, 0);
    repeat (3) drive(0, 3'd4, 0);
    chk("t5_gap_no_token", 32'(out_valid), 32'd0);
    repeat (2) drive(1, 3'd4, 0);
    expect_tok(3'd4, 4'd3);
    repeat (5) drive(0, 3'd0, 1);
    drive(0, 3'd0, 0);
    drain("t5");

    // 6: reset with tokens buffered and a run pending
    out_ready = 1'b0;
    drive(1, 3'd1, 0);
    drive(1, 3'd2, 0);
    drive(1, 3'd3, 0);
    chk("t6_buffered", 32'(fifo_count), 32'd2);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("t6_rst_valid",    32'(out_valid),  32'd0);
    chk("t6_rst_count",    32'(fifo_count), 32'd0);
    chk("t6_rst_in_ready", 32'(in_ready),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) drive(1, 3'd6, 0);
    expect_tok(3'd6, 4'd2);
    drive(0, 3'd0, 1);
    drive(0, 3'd0, 0);
    drain("t6");
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
